// File: rtl/alu_cond_stage.sv
// Execute-to-writeback stage: holds NZCV, evaluates the condition field and
// buffers the ALU result with condition-gated write enables behind valid/ready.
module alu_cond_stage #(
    parameter int          DATA_W      = 32,
    parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    input  logic [2:0]        alu_control,
    input  logic [3:0]        cond,
    input  logic [1:0]        flag_w,
    input  logic              reg_w_req,
    input  logic              mem_w_req,
    input  logic              pc_s_req,
    input  logic              no_write,
    output logic              cond_ex,
    output logic [3:0]        flags_q,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_result,
    output logic              wb_reg_w,
    output logic              wb_mem_w,
    output logic              wb_pc_w,
    output logic              wb_cond_ex
);

    localparam logic [2:0] ALU_MUL = 3'b111;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t            state_q, state_d;
    logic [3:0]        flags_d;
    logic [DATA_W-1:0] result_q;
    logic              reg_w_q, mem_w_q, pc_w_q, cond_ex_q;
    logic              accept;
    logic              n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'h0: cond_ex = z_f;
            4'h1: cond_ex = !z_f;
            4'h2: cond_ex = c_f;
            4'h3: cond_ex = !c_f;
            4'h4: cond_ex = n_f;
            4'h5: cond_ex = !n_f;
            4'h6: cond_ex = v_f;
            4'h7: cond_ex = !v_f;
            4'h8: cond_ex = c_f & !z_f;
            4'h9: cond_ex = !c_f | z_f;
            4'hA: cond_ex = (n_f == v_f);
            4'hB: cond_ex = (n_f != v_f);
            4'hC: cond_ex = !z_f & (n_f == v_f);
            4'hD: cond_ex = z_f | (n_f != v_f);
            default: cond_ex = 1'b1;
        endcase
    end

    // A full buffer can still accept when writeback drains it in the same cycle.
    assign wb_valid = (state_q == FULL);
    assign ex_ready = !wb_valid | wb_ready;
    assign accept   = ex_valid & ex_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (wb_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // MUL leaves C/V untouched even when a CV update is requested.
    always_comb begin
        flags_d = flags_q;
        if (accept && cond_ex) begin
            if (flag_w[1]) flags_d[3:2] = alu_flags[3:2];
            if (flag_w[0] && (alu_control != ALU_MUL)) flags_d[1:0] = alu_flags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            flags_q   <= RESET_FLAGS;
            result_q  <= '0;
            reg_w_q   <= 1'b0;
            mem_w_q   <= 1'b0;
            pc_w_q    <= 1'b0;
            cond_ex_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            if (accept) begin
                result_q  <= alu_result;
                reg_w_q   <= reg_w_req & !no_write & cond_ex;
                mem_w_q   <= mem_w_req & cond_ex;
                pc_w_q    <= pc_s_req & cond_ex;
                cond_ex_q <= cond_ex;
            end
        end
    end

    assign wb_result  = result_q;
    assign wb_reg_w   = reg_w_q;
    assign wb_mem_w   = mem_w_q;
    assign wb_pc_w    = pc_w_q;
    assign wb_cond_ex = cond_ex_q;

endmodule

// File: doc/alu_cond_stage.md
Name: alu_cond_stage

Overview:
- Execute-to-writeback stage directly downstream of the ALU in the multicycle MCU.
- Captures the ALU Result and ALUFlags into a one-entry output buffer.
- Holds the architectural NZCV flag register and evaluates the 4-bit condition field against it.
- Gates flag, register, memory and PC write enables with the condition outcome; results pass to writeback over a valid/ready handshake.

Parameters:
- DATA_W, 32, width of the ALU result path.
- RESET_FLAGS, 4'b0000, value loaded into flags_q {N,Z,C,V} on reset.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- ex_valid  input  1  execute stage presents a completed ALU operation
- ex_ready  output  1  stage can accept the operation this cycle
- alu_result  input  DATA_W  ALU Result
- alu_flags  input  4  ALU flags {N,Z,C,V}
- alu_control  input  3  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 B-PASS, 111 MUL
- cond  input  4  instruction condition field
- flag_w  input  2  [1] requests an NZ update, [0] requests a CV update
- reg_w_req, mem_w_req, pc_s_req  input  1 each  ungated write requests from the decoder
- no_write  input  1  compare-type instruction; suppresses the register write
- cond_ex  output  1  combinational condition result against the current flags_q
- flags_q  output  4  architectural {N,Z,C,V}
- wb_valid  output  1  buffer holds a result
- wb_ready  input  1  writeback consumes this cycle
- wb_result  output  DATA_W  buffered result
- wb_reg_w, wb_mem_w, wb_pc_w  output  1 each  buffered, condition-gated write enables
- wb_cond_ex  output  1  buffered cond_ex of the held operation

Behaviour:
- Reset, synchronous:
  - flags_q=RESET_FLAGS, wb_valid=0, wb_result=0, wb_reg_w=wb_mem_w=wb_pc_w=0, wb_cond_ex=0.
  - Reset overrides an accept in the same cycle. An in-flight buffered result is discarded.
- cond_ex is purely combinational from cond and flags_q:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F 1 (treated as unconditional).
- Buffer FSM, states EMPTY and FULL:
  - ex_ready = !wb_valid | wb_ready (pass-through allowed).
  - accept = ex_valid & ex_ready.
  - EMPTY & accept -> FULL.
  - FULL & wb_ready & !accept -> EMPTY.
  - FULL & wb_ready & accept -> FULL, with the new entry replacing the old in the same edge.
  - FULL & !wb_ready -> hold. All wb_* outputs stay stable and ex_ready=0.
- On accept, load the buffer as follows:
  - wb_result=alu_result; wb_cond_ex=cond_ex.
  - wb_reg_w = reg_w_req & !no_write & cond_ex.
  - wb_mem_w = mem_w_req & cond_ex.
  - wb_pc_w = pc_s_req & cond_ex.
- Latency: one cycle from accept to wb_valid.
- Flag update happens only on accept and only when cond_ex=1:
  - flag_w[1]=1: N,Z <- alu_flags[3:2].
  - flag_w[0]=1 and alu_control!=111: C,V <- alu_flags[1:0].
  - MUL never alters C/V, even when flag_w[0]=1.
  - flag_w=00 or cond_ex=0: flags unchanged.
- cond_ex uses flags_q before the update, so a flag-setting op followed back-to-back by a conditional op sees the new flags, because the second op is accepted a cycle later.
- No accept means no state change except the drain of the FULL buffer.
- alu_result X (undefined opcode) is stored as-is; the bench must not issue such ops.

Test Plan:
- Reset, then SUB with alu_result=0, alu_flags=0110, flag_w=11, cond=E, reg_w_req=1, no_write=1, wb_ready=1 -> next cycle wb_valid=1, wb_result=0, wb_reg_w=0, flags_q=0110. A following op with cond=0 gives cond_ex=1; with cond=1 it gives cond_ex=0.
- flags_q=0110, MUL with alu_flags=1000, flag_w=11 -> flags_q=1010 (NZ updated, C/V retained).
- flags_q=0000, cond=0 (EQ), ADD with reg_w_req=1, mem_w_req=1, flag_w=11, alu_flags=1111 -> wb_reg_w=0, wb_mem_w=0, wb_cond_ex=0, flags_q stays 0000.
- wb_ready=0 with ex_valid held and a result 0x1234 buffered -> ex_ready=0 for 3 cycles, wb_result stays 0x1234. Raise wb_ready -> the next op is accepted the same cycle and its result appears one cycle later.
- Back-to-back accepts with wb_ready=1, results 0xA,0xB,0xC -> wb_result shows 0xA,0xB,0xC on consecutive cycles with wb_valid high throughout.
- Sweep all 16 cond codes over all 16 flags_q values -> cond_ex matches the table above. Assert reset while FULL -> wb_valid=0 and flags_q=RESET_FLAGS next cycle.
